// File: rtl/audio_pkg.sv
// Shared constants and helpers for the HDMI audio preparation path.
package audio_pkg;

  localparam logic [1:0] VOL_MUTE  = 2'd0;
  localparam logic [1:0] VOL_M12   = 2'd1;
  localparam logic [1:0] VOL_M6    = 2'd2;
  localparam logic [1:0] VOL_UNITY = 2'd3;

  // Half period of the audio clock in system clocks (integer division).
  function automatic int calc_half(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz / 2;
  endfunction

  function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v,
                                                      input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/audio_onepole.sv
// One-pole IIR low-pass: acc += x - acc/2^K, output is acc/2^K (floor).
module audio_onepole #(
  parameter int IN_W = 18,
  parameter int K    = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic signed [IN_W-1:0] x,
  output logic signed [IN_W-1:0] y
);

  localparam int ACC_W = IN_W + K + 1;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] fb;

  always_comb begin
    fb    = acc_q >>> K;
    acc_d = acc_q;
    if (en) acc_d = acc_q + ACC_W'(x) - fb;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  assign y = fb[IN_W-1:0];

endmodule

// File: rtl/audio_hdmi_prep.sv
// Filters, decimates, saturates and scales stereo audio into the HDMI audio
// sample word, and generates the 48 kHz audio clock as a register.
module audio_hdmi_prep
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = 31500000,
  parameter int SAMPLE_HZ = 48000,
  parameter int IN_W      = 18,
  parameter int OUT_W     = 16,
  parameter int K         = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] audio_l,
  input  logic signed [IN_W-1:0] audio_r,
  input  logic [1:0]             volume,
  output logic                   clk_audio,
  output logic [2*OUT_W-1:0]     sample_word,
  output logic                   sample_strobe
);

  localparam int HALF  = calc_half(CLK_HZ, SAMPLE_HZ);
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
  // One bit less than the width difference: keeps +6 dB of headroom gain.
  localparam int SHIFT = IN_W - OUT_W - 1;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clk_audio_q, clk_audio_d;
  logic [2*OUT_W-1:0]     sample_word_q, sample_word_d;
  logic                   sample_strobe_q, sample_strobe_d;

  logic signed [IN_W-1:0]  filt_l, filt_r;
  logic signed [31:0]      wide_l, wide_r;
  logic signed [OUT_W-1:0] sat_l, sat_r;
  logic signed [OUT_W-1:0] vol_l, vol_r;
  logic                    wrap;
  logic                    capture;

  audio_onepole #(.IN_W(IN_W), .K(K)) u_filt_l (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (in_valid),
    .x       (audio_l),
    .y       (filt_l)
  );

  audio_onepole #(.IN_W(IN_W), .K(K)) u_filt_r (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (in_valid),
    .x       (audio_r),
    .y       (filt_r)
  );

  always_comb begin
    wrap        = (cnt_q == CNT_LAST);
    cnt_d       = wrap ? '0 : cnt_q + CNT_W'(1);
    clk_audio_d = clk_audio_q ^ wrap;
    // Capture on the 1->0 toggle so the word is stable a half period ahead.
    capture     = wrap & clk_audio_q;

    wide_l = 32'(filt_l) >>> SHIFT;
    wide_r = 32'(filt_r) >>> SHIFT;
    sat_l  = OUT_W'(sat_to_width(wide_l, OUT_W));
    sat_r  = OUT_W'(sat_to_width(wide_r, OUT_W));

    vol_l = sat_l;
    vol_r = sat_r;
    case (volume)
      VOL_MUTE: begin
        vol_l = '0;
        vol_r = '0;
      end
      VOL_M12: begin
        vol_l = sat_l >>> 2;
        vol_r = sat_r >>> 2;
      end
      VOL_M6: begin
        vol_l = sat_l >>> 1;
        vol_r = sat_r >>> 1;
      end
      default: begin
        vol_l = sat_l;
        vol_r = sat_r;
      end
    endcase

    sample_word_d   = capture ? {vol_l, vol_r} : sample_word_q;
    sample_strobe_d = capture;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q           <= '0;
      clk_audio_q     <= 1'b0;
      sample_word_q   <= '0;
      sample_strobe_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      clk_audio_q     <= clk_audio_d;
      sample_word_q   <= sample_word_d;
      sample_strobe_q <= sample_strobe_d;
    end
  end

  assign clk_audio     = clk_audio_q;
  assign sample_word   = sample_word_q;
  assign sample_strobe = sample_strobe_q;

endmodule

// File: tb/tb_audio_hdmi_prep.sv
// Directed bench for audio_hdmi_prep: divider timing, filter/saturation/volume
// vectors, input freeze and mid-period reset.
module tb_audio_hdmi_prep;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic signed [17:0] audio_l;
  logic signed [17:0] audio_r;
  logic [1:0]         volume;
  logic               clk_audio;
  logic [31:0]        sample_word;
  logic               sample_strobe;

  int n_cmp = 0;
  int n_bad = 0;

  audio_hdmi_prep dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .audio_l       (audio_l),
    .audio_r       (audio_r),
    .volume        (volume),
    .clk_audio     (clk_audio),
    .sample_word   (sample_word),
    .sample_strobe (sample_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          in_l;
    int          in_r;
    logic [1:0]  vol;
    int          settle;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(posedge clk);
      #1;
      if (sample_strobe) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no strobe within 2000 clks, want one", tag);
    end
  endtask

  // Every strobe must coincide with a 1->0 step of clk_audio and vice versa.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) prev = 1'b0;
      else begin
        if (sample_strobe || (prev && !clk_audio))
          check("strobe_on_fall", 32'(sample_strobe), 32'(prev && !clk_audio));
        prev = clk_audio;
      end
    end
  end

  initial begin
    int bad_ca, bad_st, n_st, first_st;
    int lv, rv, prev_l, prev_r, viol, caps;
    bit reached;
    int first_rise;

    vecs[0] = '{4000,    -4000,   2'd3, 2, 32'h07D0_F830};
    vecs[1] = '{4000,    -4000,   2'd2, 1, 32'h03E8_FC18};
    vecs[2] = '{4000,    -4000,   2'd1, 1, 32'h01F4_FE0C};
    vecs[3] = '{4000,    -4000,   2'd0, 1, 32'h0000_0000};
    vecs[4] = '{6,       -7,      2'd3, 3, 32'h0003_FFFC};
    vecs[5] = '{131071,  -131072, 2'd3, 4, 32'h7FFF_8000};
    vecs[6] = '{-131072, 131071,  2'd3, 4, 32'h8000_7FFF};
    vecs[7] = '{-131072, 131071,  2'd1, 1, 32'hE000_1FFF};
    vecs[8] = '{4000,    -4000,   2'd3, 6, 32'h07D0_F830};

    // Reset state and divider pattern
    reset_n  = 1'b0;
    in_valid = 1'b0;
    audio_l  = '0;
    audio_r  = '0;
    volume   = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_word", sample_word, 32'h0);
    check("reset_strobe", 32'(sample_strobe), 32'h0);
    check("reset_clk_audio", 32'(clk_audio), 32'h0);

    @(negedge clk);
    reset_n = 1'b1;
    bad_ca = 0; bad_st = 0; n_st = 0; first_st = 0;
    for (int n = 1; n <= 5000; n++) begin
      @(posedge clk);
      #1;
      if (clk_audio !== 1'((n / 328) % 2)) bad_ca++;
      if (sample_strobe !== (n % 656 == 0)) bad_st++;
      if (sample_strobe) begin
        n_st++;
        if (first_st == 0) first_st = n;
      end
    end
    check("clk_audio_pattern_errs", 32'(bad_ca), 32'd0);
    check("strobe_pattern_errs", 32'(bad_st), 32'd0);
    check("strobe_count_5000", 32'(n_st), 32'd7);
    check("first_strobe_cycle", 32'(first_st), 32'd656);
    check("idle_word", sample_word, 32'h0);

    // Step response from 0 to +/-4000 (s = filt/2, so +/-2000)
    in_valid = 1'b1;
    audio_l  = 18'sd4000;
    audio_r  = -18'sd4000;
    prev_l = 0; prev_r = 0; viol = 0; caps = 0; reached = 1'b0;
    for (int n = 1; n <= 1500; n++) begin
      @(posedge clk);
      #1;
      if (sample_strobe) begin
        lv = int'($signed(sample_word[31:16]));
        rv = int'($signed(sample_word[15:0]));
        caps++;
        if (lv < prev_l || lv > 2000 || rv > prev_r || rv < -2000) viol++;
        if (lv == 2000 && rv == -2000) reached = 1'b1;
        prev_l = lv;
        prev_r = rv;
      end
    end
    check("step_captures", 32'(caps), 32'd2);
    check("step_monotonic_errs", 32'(viol), 32'd0);
    check("step_reached_2000", 32'(reached), 32'd1);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      audio_l = 18'(vecs[i].in_l);
      audio_r = 18'(vecs[i].in_r);
      volume  = vecs[i].vol;
      for (int s = 0; s < vecs[i].settle; s++) wait_strobe($sformatf("vec%0d_wait", i));
      check($sformatf("vec%0d_word", i), sample_word, vecs[i].exp_word);
    end

    // Input frozen: filter holds, captures keep the last value
    in_valid = 1'b0;
    audio_l  = '0;
    audio_r  = '0;
    caps = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk);
      #1;
      if (sample_strobe) begin
        caps++;
        check($sformatf("freeze_cap%0d", caps), sample_word, 32'h07D0_F830);
      end
    end
    check("freeze_captures_ge4", 32'(caps >= 4), 32'd1);

    // Mid-period reset
    begin
      bit hi;
      hi = 1'b0;
      for (int k = 0; k < 1000 && !hi; k++) begin
        @(posedge clk);
        #1;
        hi = clk_audio;
      end
      check("clk_audio_high_seen", 32'(hi), 32'd1);
    end
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_word", sample_word, 32'h0);
    check("midreset_clk_audio", 32'(clk_audio), 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    first_rise = 0; first_st = 0;
    for (int n = 1; n <= 2000 && first_st == 0; n++) begin
      @(posedge clk);
      #1;
      if (clk_audio && first_rise == 0) first_rise = n;
      if (sample_strobe) first_st = n;
    end
    check("post_reset_first_rise", 32'(first_rise), 32'd328);
    check("post_reset_first_strobe", 32'(first_st), 32'd656);
    check("post_reset_word", sample_word, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
